// File: rtl/key_digit_reader.sv
// key_digit_reader
//   Reads two active-low push buttons and a 4-bit switch bank and builds a
//   six-digit BCD value, one digit per ENTER press, most significant digit
//   first. The result feeds the seven-segment encoders in place of constants.
//
//   Each key passes through a 2-flop synchroniser, a counter-based debouncer
//   and a falling-edge detector that yields a one-cycle press pulse. The press
//   pulses drive a two-state digit-entry FSM (ENTRY, DONE).
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high
//   switch      in   4   digit to load (binary, 0-9 legal); sampled in the
//                        press-pulse cycle only, not synchronised
//   key         in   2   buttons, active-low; key[0]=ENTER, key[1]=CLEAR
//   digits      out  24  six BCD nibbles, [23:20]=hex5 ... [3:0]=hex0
//   digit_ptr   out  3   index of the next digit to write, 5 down to 0
//   entry_done  out  1   high once all six digits are loaded
//   error       out  1   one-cycle pulse: ENTER with switch > 9
module key_digit_reader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  switch,
    input  logic [1:0]  key,
    output logic [23:0] digits,
    output logic [2:0]  digit_ptr,
    output logic        entry_done,
    output logic        error
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ENTRY = 1'b0,
        DONE  = 1'b1
    } state_t;

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    logic [1:0]       key_p0;
    logic [1:0]       key_p1;
    logic [CNT_W-1:0] cnt_p2 [2];
    logic [1:0]       deb_p2;
    logic [1:0]       deb_dly_p3;
    logic [1:0]       press_p3;

    state_t      state;
    state_t      state_n;
    logic [23:0] digits_n;
    logic [2:0]  ptr_n;
    logic        done_n;
    logic        error_n;
    logic        enter;
    logic        clear;

    // ---- stage p0/p1: two-flop synchroniser, idles at released (1) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            key_p0 <= 2'b11;
            key_p1 <= 2'b11;
        end else begin
            key_p0 <= key;
            key_p1 <= key_p0;
        end
    end

    // ---- stage p2: debounce; a level is accepted only after it has
    //      disagreed with the current debounced level for DEBOUNCE_CYCLES
    //      consecutive cycles, any agreement restarts the count ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                cnt_p2[i] <= '0;
            end
            deb_p2 <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_p1[i] == deb_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    deb_p2[i] <= key_p1[i];
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    // ---- stage p3: registered falling-edge detect -> one-cycle press ----
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_dly_p3 <= 2'b11;
            press_p3   <= 2'b00;
        end else begin
            deb_dly_p3 <= deb_p2;
            press_p3   <= deb_dly_p3 & ~deb_p2;
        end
    end

    assign enter = press_p3[0];
    assign clear = press_p3[1];

    // ---- stage p4: digit-entry FSM and registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ENTRY;
            digits     <= 24'h000000;
            digit_ptr  <= 3'd5;
            entry_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            digits     <= digits_n;
            digit_ptr  <= ptr_n;
            entry_done <= done_n;
            error      <= error_n;
        end
    end

    always_comb begin
        state_n  = state;
        digits_n = digits;
        ptr_n    = digit_ptr;
        done_n   = entry_done;
        error_n  = 1'b0;

        // CLEAR has priority; a simultaneous ENTER is dropped.
        if (clear) begin
            state_n  = ENTRY;
            digits_n = 24'h000000;
            ptr_n    = 3'd5;
            done_n   = 1'b0;
        end else if (enter) begin
            case (state)
                ENTRY: begin
                    if (is_bcd(switch)) begin
                        digits_n[{digit_ptr, 2'b00} +: 4] = switch;
                        if (digit_ptr == 3'd0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            ptr_n = digit_ptr - 3'd1;
                        end
                    end else begin
                        error_n = 1'b1;
                    end
                end
                DONE: begin
                    // Entry complete: further ENTER presses are ignored.
                end
                default: begin
                    state_n = ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_digit_reader.sv
module tb_key_digit_reader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  switch;
    logic [1:0]  key;
    logic [23:0] digits;
    logic [2:0]  digit_ptr;
    logic        entry_done;
    logic        error;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    key_digit_reader #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .switch    (switch),
        .key       (key),
        .digits    (digits),
        .digit_ptr (digit_ptr),
        .entry_done(entry_done),
        .error     (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. A key's accepted level flips once the pin value seen
    // two cycles late has differed from it on D consecutive cycles. A 1->0
    // flip becomes a press that the entry logic acts on two edges later.
    // ------------------------------------------------------------------
    bit         hist   [2][D+1];   // pin samples, oldest first
    bit         mdeb   [2];
    bit         mfell  [2];
    bit         mpulse [2];
    logic [3:0] mdig   [6];
    int         mptr;
    bit         mdone;
    bit         merr;

    function automatic logic [23:0] mdigits();
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = mdig[i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j <= D; j++) hist[k][j] = 1'b1;
                mdeb[k]   = 1'b1;
                mfell[k]  = 1'b0;
                mpulse[k] = 1'b0;
            end
            for (int i = 0; i < 6; i++) mdig[i] = 4'd0;
            mptr  = 5;
            mdone = 1'b0;
            merr  = 1'b0;
        end else begin
            merr = 1'b0;
            if (mpulse[1]) begin
                for (int i = 0; i < 6; i++) mdig[i] = 4'd0;
                mptr  = 5;
                mdone = 1'b0;
            end else if (mpulse[0] && !mdone) begin
                if (switch <= 9) begin
                    mdig[mptr] = switch;
                    if (mptr == 0) mdone = 1'b1;
                    else mptr = mptr - 1;
                end else begin
                    merr = 1'b1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                bit all_diff;
                mpulse[k] = mfell[k];
                all_diff  = 1'b1;
                for (int j = 0; j < D; j++) if (hist[k][j] == mdeb[k]) all_diff = 1'b0;
                mfell[k] = 1'b0;
                if (all_diff) begin
                    mfell[k] = mdeb[k];
                    mdeb[k]  = ~mdeb[k];
                end
                for (int j = 0; j < D; j++) hist[k][j] = hist[k][j+1];
                hist[k][D] = key[k];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_digits", 32'(digits), 32'(mdigits()));
            chk("cyc_ptr", 32'(digit_ptr), 32'(mptr));
            chk("cyc_done", 32'(entry_done), 32'(mdone));
            chk("cyc_error", 32'(error), 32'(merr));
        end
    end

    // ------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  low;    // keys driven low (bit0 ENTER, bit1 CLEAR)
        logic [3:0]  sw;
        int          hold;
        logic [23:0] dig;
        logic [2:0]  ptr;
        logic        done;
        int          errs;   // cycles error is expected high
    } vec_t;

    vec_t tbl [18];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic op(input logic [1:0] low, input logic [3:0] sw, input int hold, output int ec);
        ec     = 0;
        switch = sw;
        key    = ~low;
        for (int i = 0; i < hold + 12; i++) begin
            @(negedge clk);
            if (error) ec++;
            if (i == hold - 1) key = 2'b11;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ec;
        int n;

        tbl[0]  = '{2'b01, 4'd3,  3, 24'h000000, 3'd5, 1'b0, 0};
        tbl[1]  = '{2'b01, 4'd3,  6, 24'h300000, 3'd4, 1'b0, 0};
        tbl[2]  = '{2'b10, 4'd0, 10, 24'h000000, 3'd5, 1'b0, 0};
        tbl[3]  = '{2'b01, 4'd0, 10, 24'h000000, 3'd4, 1'b0, 0};
        tbl[4]  = '{2'b01, 4'd8, 10, 24'h080000, 3'd3, 1'b0, 0};
        tbl[5]  = '{2'b01, 4'd2, 10, 24'h082000, 3'd2, 1'b0, 0};
        tbl[6]  = '{2'b01, 4'd0, 10, 24'h082000, 3'd1, 1'b0, 0};
        tbl[7]  = '{2'b01, 4'd0, 10, 24'h082000, 3'd0, 1'b0, 0};
        tbl[8]  = '{2'b01, 4'd1, 10, 24'h082001, 3'd0, 1'b1, 0};
        tbl[9]  = '{2'b01, 4'd9, 10, 24'h082001, 3'd0, 1'b1, 0};
        tbl[10] = '{2'b10, 4'd0, 10, 24'h000000, 3'd5, 1'b0, 0};
        tbl[11] = '{2'b01, 4'hC, 10, 24'h000000, 3'd5, 1'b0, 1};
        tbl[12] = '{2'b01, 4'd7, 10, 24'h700000, 3'd4, 1'b0, 0};
        tbl[13] = '{2'b01, 4'd3, 10, 24'h730000, 3'd3, 1'b0, 0};
        tbl[14] = '{2'b01, 4'd5, 10, 24'h735000, 3'd2, 1'b0, 0};
        tbl[15] = '{2'b10, 4'd0, 10, 24'h000000, 3'd5, 1'b0, 0};
        tbl[16] = '{2'b01, 4'd4, 10, 24'h400000, 3'd4, 1'b0, 0};
        tbl[17] = '{2'b11, 4'd6, 10, 24'h000000, 3'd5, 1'b0, 0};

        reset  = 1'b1;
        key    = 2'b11;
        switch = 4'd0;
        tick(3);
        reset = 1'b0;
        chk("rst_digits", 32'(digits), 32'h000000);
        chk("rst_ptr", 32'(digit_ptr), 32'd5);
        chk("rst_done", 32'(entry_done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            op(tbl[i].low, tbl[i].sw, tbl[i].hold, ec);
            chk($sformatf("v%0d_digits", i), 32'(digits), 32'(tbl[i].dig));
            chk($sformatf("v%0d_ptr", i), 32'(digit_ptr), 32'(tbl[i].ptr));
            chk($sformatf("v%0d_done", i), 32'(entry_done), 32'(tbl[i].done));
            chk($sformatf("v%0d_errcycles", i), 32'(ec), 32'(tbl[i].errs));
        end

        // Reset while ENTER is held mid-debounce; the held key must come
        // back as one fresh press after reset is released.
        switch = 4'd5;
        key    = 2'b10;
        tick(3);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("midrst_digits", 32'(digits), 32'h000000);
        chk("midrst_ptr", 32'(digit_ptr), 32'd5);
        chk("midrst_done", 32'(entry_done), 32'd0);
        n = 0;
        while (digit_ptr == 3'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_latency", 32'(n), 32'(D + 4));
        tick(6);
        key = 2'b11;
        tick(12);
        chk("midrst_one_write_digits", 32'(digits), 32'h500000);
        chk("midrst_one_write_ptr", 32'(digit_ptr), 32'd4);

        // Randomised presses, bounces, clears and resets, checked each cycle.
        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 9);
            switch = 4'($urandom_range(0, 15));
            key    = (r < 7) ? 2'b10 : (r < 9) ? 2'b01 : 2'b00;
            tick($urandom_range(1, 9));
            key = 2'b11;
            tick($urandom_range(0, 10));
            if (it % 50 == 49) begin
                reset = 1'b1;
                tick($urandom_range(1, 3));
                reset = 1'b0;
                tick(2);
            end
        end
        tick(15);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
